// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transceiver. Holds the
//                parity-mode constants, the state encoding used by both the
//                TX and RX state machines, and a parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Parity bit that brings the total count of ones (data + parity) to odd
    // or even. data_xor is the XOR-reduction of the payload.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Loadable down-counter generating one tick per bit period.
//                'start' loads a full period (or half a period when 'half'
//                is set); after the first tick it auto-reloads a full period,
//                so ticks keep landing at the same phase within each bit.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                start      - (re)load the counter
//                half       - with start, load CLKS_PER_BIT/2 instead
//                tick       - high for one cycle at the end of each period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic half,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [CW-1:0] count;
    logic          running;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= half ? HALF_LOAD : FULL_LOAD;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                count <= FULL_LOAD;
            end else begin
                count <= count - ONE;
            end
        end
    end

    assign tick = running && (count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
//  Module      : uart_xcvr
//  Description : Full-duplex UART transceiver with configurable payload
//                width, parity mode and stop-bit count. TX and RX run
//                independently, each paced by its own uart_bit_timer.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                tx_data/valid/ready   - transmit handshake
//                txd                   - serial out, idle high
//                rxd                   - asynchronous serial in
//                rx_data/valid/ready   - receive handshake
//                rx_frame_err          - stop sample of rx_data's frame was low
//                rx_parity_err         - parity of rx_data's frame mismatched
//                rx_overrun            - one-cycle pulse when a byte is dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t          tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic [2:0]           tx_bit_cnt;
    logic                 tx_stop_cnt;
    logic                 tx_par;
    logic                 tx_tick;
    logic                 tx_accept;

    assign tx_accept = (tx_state == ST_IDLE) && tx_ready && tx_valid;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk   (clk),
        .rst   (rst),
        .start (tx_accept),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= ST_IDLE;
            txd         <= 1'b1;
            tx_ready    <= 1'b0;
            tx_shift    <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
            tx_par      <= 1'b0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (tx_accept) begin
                        tx_ready <= 1'b0;
                        txd      <= 1'b0;
                        tx_shift <= tx_data;
                        tx_par   <= parity_bit(^tx_data, PARITY);
                        tx_state <= ST_START;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_tick) begin
                        txd        <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_cnt <= '0;
                        tx_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit_cnt == LAST_BIT) begin
                            if (PARITY != PAR_NONE) begin
                                txd      <= tx_par;
                                tx_state <= ST_PARITY;
                            end else begin
                                txd         <= 1'b1;
                                tx_stop_cnt <= 1'b0;
                                tx_state    <= ST_STOP;
                            end
                        end else begin
                            txd        <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                            tx_bit_cnt <= tx_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tx_tick) begin
                        txd         <= 1'b1;
                        tx_stop_cnt <= 1'b0;
                        tx_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tx_tick) begin
                        if (tx_stop_cnt == LAST_STOP) begin
                            tx_ready <= 1'b1;
                            tx_state <= ST_IDLE;
                        end else begin
                            tx_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    txd      <= 1'b1;
                    tx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]           rx_sync;
    logic [1:0]           rx_fill;   // marks when rx_sync holds real line samples
    logic                 rx_s;
    logic                 rx_armed;  // line seen high; a low level is a start edge
    uart_state_t          rx_state;
    logic [DATA_BITS-1:0] rx_shift;
    logic [2:0]           rx_bit_cnt;
    logic                 rx_pbit;
    logic                 rx_tick;
    logic                 rx_begin;

    assign rx_s     = rx_sync[1];
    assign rx_begin = (rx_state == ST_IDLE) && rx_armed && !rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_fill <= 2'b00;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rx_fill <= {rx_fill[0], 1'b1};
        end
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk   (clk),
        .rst   (rst),
        .start (rx_begin),
        .half  (1'b1),
        .tick  (rx_tick)
    );

    // Arming requires a genuine high sample, so a line held low through
    // reset or after a break never fabricates a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= ST_IDLE;
            rx_armed      <= 1'b0;
            rx_shift      <= '0;
            rx_bit_cnt    <= '0;
            rx_pbit       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_armed) begin
                        if (rx_fill[1] && rx_s) begin
                            rx_armed <= 1'b1;
                        end
                    end else if (!rx_s) begin
                        rx_armed <= 1'b0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_tick) begin
                        if (rx_s) begin
                            rx_armed <= 1'b1;
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_bit_cnt <= '0;
                            rx_state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_cnt == LAST_BIT) begin
                            rx_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (rx_tick) begin
                        rx_pbit  <= rx_s;
                        rx_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (rx_tick) begin
                        rx_state <= ST_IDLE;
                        rx_armed <= rx_s;
                        // A handshake in this same cycle frees the slot,
                        // and the later assignment below wins.
                        if (rx_valid && !rx_ready) begin
                            rx_overrun <= 1'b1;
                        end else begin
                            rx_valid      <= 1'b1;
                            rx_data       <= rx_shift;
                            rx_frame_err  <= !rx_s;
                            rx_parity_err <= (PARITY != PAR_NONE) &&
                                             (rx_pbit != parity_bit(^rx_shift, PARITY));
                        end
                    end
                end
                default: begin
                    rx_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_xcvr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_xcvr
//  Description : Self-checking bench for uart_xcvr (CLKS_PER_BIT=16, 8 data
//                bits). dut_a has no parity and checks the TX waveform;
//                dut_b uses even parity for loopback and RX corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_xcvr;
    import uart_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // dut_a: PARITY=0
    logic [7:0] a_tx_data  = 8'h00;
    logic       a_tx_valid = 1'b0;
    logic       a_tx_ready, a_txd;
    logic       a_rxd      = 1'b1;
    logic [7:0] a_rx_data;
    logic       a_rx_valid, a_ferr, a_perr, a_ovr;
    logic       a_rx_ready = 1'b1;

    // dut_b: PARITY=2
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd;
    logic       rxd;
    logic       rx_drv   = 1'b1;
    logic       loop_en  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err, rx_overrun;
    logic       rx_ready = 1'b1;

    assign rxd = loop_en ? txd : rx_drv;

    uart_xcvr #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .txd(a_txd),
        .rxd(a_rxd), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
        .rx_frame_err(a_ferr), .rx_parity_err(a_perr), .rx_overrun(a_ovr)
    );

    uart_xcvr #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
        .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int pops     = 0;
    int ovr_cnt  = 0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rx_exp_t;
    rx_exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
    } tx_vec_t;
    tx_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vec_cnt++;
        miss_cnt++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Consumer side of the scoreboard: a byte is taken on rx_valid&&rx_ready.
    always @(negedge clk) begin
        #1;
        if (!rst && rx_valid && rx_ready) begin
            pops++;
            if (sb.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL rx_unexpected: got byte 0x%0h, expected no byte", rx_data);
            end else begin
                rx_exp_t e;
                e = sb.pop_front();
                check($sformatf("rx_data_%02h", e.data), {24'd0, rx_data}, {24'd0, e.data});
                check($sformatf("rx_flags_%02h", e.data), {30'd0, rx_frame_err, rx_parity_err},
                      {30'd0, e.ferr, e.perr});
            end
        end
        if (!rst && rx_overrun) ovr_cnt++;
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, sb.size(), 0);
    endtask

    // Offer d on dut_b TX (left valid for back-to-back), check the parity bit.
    task automatic send_tx(input logic [7:0] d, input logic exp_par);
        int t;
        tx_data  = d;
        tx_valid = 1'b1;
        t = 0;
        while (!tx_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            timeout($sformatf("tx_accept_%02h", d));
            return;
        end
        @(negedge clk);                      // first cycle of the start bit
        repeat (8 * N + N + N / 2 - 1) @(negedge clk);   // middle of the parity bit
        check($sformatf("tx_parity_%02h", d), {31'd0, txd}, {31'd0, exp_par});
    endtask

    // Bit-bang one even-parity frame onto rx_drv; optionally raise rx_ready
    // at a given cycle offset from the start of the frame.
    task automatic drive_frame(input logic [7:0] d, input logic par_flip,
                               input logic stop_lvl, input int ready_at);
        logic [10:0] bits;
        int cyc;
        bits = {stop_lvl, (^d) ^ par_flip, d, 1'b0};
        cyc = 0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < N; c++) begin
                rx_drv = bits[b];
                if (cyc == ready_at) rx_ready = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_bits;
        int match, low_cnt, p0, o0;

        vecs[0] = '{8'h00, 1'b0};
        vecs[1] = '{8'hFF, 1'b0};
        vecs[2] = '{8'h55, 1'b0};
        vecs[3] = '{8'h07, 1'b1};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'hC3, 1'b0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_txd", {30'd0, txd, a_txd}, 32'h3);
        check("rst_tx_ready", {30'd0, tx_ready, a_tx_ready}, 32'h0);
        check("rst_rx_valid", {30'd0, rx_valid, a_rx_valid}, 32'h0);
        check("rst_rx_data", {24'd0, rx_data}, 32'h0);
        check("rst_rx_flags", {29'd0, rx_frame_err, rx_parity_err, rx_overrun}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", {30'd0, tx_ready, a_tx_ready}, 32'h3);

        // ---------------- 0xA5, no parity, waveform ----------------
        a5_bits = {1'b1, 8'hA5, 1'b0};
        a_tx_data  = 8'hA5;
        a_tx_valid = 1'b1;
        @(negedge clk);                      // accepted at the edge just passed
        a_tx_valid = 1'b0;
        low_cnt = 0;
        for (int b = 0; b < 10; b++) begin
            match = 0;
            for (int c = 0; c < N; c++) begin
                if (a_txd === a5_bits[b]) match++;
                if (a_tx_ready === 1'b0) low_cnt++;
                @(negedge clk);
            end
            check($sformatf("a5_bit%0d_cycles", b), match, N);
        end
        check("a5_ready_low_cycles", low_cnt, 160);
        check("a5_after_frame", {30'd0, a_tx_ready, a_txd}, 32'h3);

        // ---------------- loopback, back-to-back, even parity ----------------
        loop_en  = 1'b1;
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{vecs[i].data, 1'b0, 1'b0});
            send_tx(vecs[i].data, vecs[i].par);
        end
        tx_valid = 1'b0;
        wait_drain("loopback");

        // ---------------- glitch rejection ----------------
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (20) @(negedge clk);
        p0 = pops;
        rx_drv = 1'b0;
        repeat (6) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", pops - p0, 0);
        check("glitch_rx_idle", dut_b.rx_state, ST_IDLE);
        sb.push_back('{8'h5A, 1'b0, 1'b0});
        drive_frame(8'h5A, 1'b0, 1'b1, -1);
        rx_drv = 1'b1;
        wait_drain("after_glitch");

        // ---------------- parity error ----------------
        sb.push_back('{8'h6B, 1'b0, 1'b1});
        drive_frame(8'h6B, 1'b1, 1'b1, -1);
        rx_drv = 1'b1;
        wait_drain("parity_err");

        // ---------------- frame error then break ----------------
        p0 = pops;
        sb.push_back('{8'h3C, 1'b1, 1'b0});
        drive_frame(8'h3C, 1'b0, 1'b0, -1);
        repeat (400) @(negedge clk);         // line still low: break
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("break_one_frame", pops - p0, 1);
        wait_drain("frame_err");
        sb.push_back('{8'hE1, 1'b0, 1'b0});
        drive_frame(8'hE1, 1'b0, 1'b1, -1);
        rx_drv = 1'b1;
        wait_drain("after_break");

        // ---------------- overrun ----------------
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        sb.push_back('{8'h11, 1'b0, 1'b0});
        drive_frame(8'h11, 1'b0, 1'b1, -1);
        drive_frame(8'h22, 1'b0, 1'b1, -1);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        check("overrun_pulses", ovr_cnt - o0, 1);
        check("overrun_kept", {23'd0, rx_valid, rx_data}, {23'd1, 8'h11});
        rx_ready = 1'b1;
        wait_drain("overrun");

        // completion in the same cycle as the handshake: no overrun
        rx_ready = 1'b0;
        sb.push_back('{8'h33, 1'b0, 1'b0});
        drive_frame(8'h33, 1'b0, 1'b1, -1);
        o0 = ovr_cnt;
        sb.push_back('{8'h44, 1'b0, 1'b0});
        drive_frame(8'h44, 1'b0, 1'b1, 170);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        check("same_cycle_no_overrun", ovr_cnt - o0, 0);
        wait_drain("same_cycle");

        // ---------------- reset mid-TX / mid-RX ----------------
        loop_en  = 1'b1;
        rx_ready = 1'b1;
        tx_data  = 8'hE7;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (60) @(negedge clk);
        p0 = pops;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", {31'd0, txd}, 32'h1);
        check("midrst_state", {30'd0, tx_ready, rx_valid}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", {31'd0, tx_ready}, 32'h1);
        repeat (300) @(negedge clk);
        check("midrst_no_frame", pops - p0, 0);
        sb.push_back('{8'h96, 1'b0, 1'b0});
        send_tx(8'h96, 1'b0);
        tx_valid = 1'b0;
        wait_drain("after_reset");

        check("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
`default_nettype wire
